// File: rtl/figan_pkg.sv
// Shared definitions for the upsample sequencing path: controller state encoding
// and the per-channel output-sample count of upsample_layer.
package figan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_PUSH  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } seq_state_e;

  // Each input row yields 2*W data/zero samples plus 2*W pad samples.
  function automatic int out_per_ch(input int in_width, input int in_height);
    return 4 * in_width * in_height;
  endfunction

endpackage

// File: rtl/upsample_addr_gen.sv
// Feature-buffer address generator: latches the frame base, walks addresses
// linearly across channels, and flags the last pixel of the current channel.
module upsample_addr_gen #(
  parameter int PIX_PER_CH = 256,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic [ADDR_WIDTH-1:0] i_base,
  input  logic                  i_adv,
  input  logic                  i_ch_clr,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_ch_end
);

  localparam int PIX_W = $clog2(PIX_PER_CH) + 1;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [PIX_W-1:0]      r_pix_cnt;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr    <= '0;
      r_pix_cnt <= '0;
    end else begin
      // Address never resets between channels, so it wraps naturally at 2^ADDR_WIDTH.
      if (i_load)     r_addr <= i_base;
      else if (i_adv) r_addr <= r_addr + ADDR_WIDTH'(1);

      if (i_load || i_ch_clr) r_pix_cnt <= '0;
      else if (i_adv)         r_pix_cnt <= r_pix_cnt + PIX_W'(1);
    end
  end

  assign o_addr   = r_addr;
  assign o_ch_end = (r_pix_cnt == PIX_W'(PIX_PER_CH - 1));

endmodule

// File: rtl/upsample_seq_ctrl.sv
// Streams a multi-channel feature map from the feature buffer into upsample_layer
// one pixel per handshake, and counts its output samples to detect channel/frame end.
module upsample_seq_ctrl
  import figan_pkg::*;
#(
  parameter int IN_WIDTH   = 16,
  parameter int IN_HEIGHT  = 16,
  parameter int NUM_CH     = 8,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [ADDR_WIDTH-1:0]     base_addr,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [$clog2(NUM_CH):0]   ch_idx,
  output logic                      mem_rd_en,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  input  logic [DATA_WIDTH-1:0]     mem_rd_data,
  output logic                      up_valid_in,
  output logic [DATA_WIDTH-1:0]     up_data_in,
  input  logic                      up_ready_in,
  input  logic                      up_valid_out
);

  localparam int PIX_PER_CH = IN_WIDTH * IN_HEIGHT;
  localparam int OUT_PER_CH = out_per_ch(IN_WIDTH, IN_HEIGHT);
  localparam int OC_W       = $clog2(OUT_PER_CH) + 1;
  localparam int CH_W       = $clog2(NUM_CH) + 1;

  seq_state_e            r_state, w_next;
  logic [OC_W-1:0]       r_out_cnt, w_out_inc;
  logic [CH_W-1:0]       r_ch_idx;
  logic                  r_busy, r_done, r_err, r_mem_rd_en, r_up_valid_in;
  logic [DATA_WIDTH-1:0] r_up_data_in;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_accept, w_hs, w_ch_end, w_last_ch;
  logic                  w_cnt_en, w_overflow, w_stray, w_cnt_hit, w_ch_clr;

  upsample_addr_gen #(
    .PIX_PER_CH (PIX_PER_CH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_accept),
    .i_base   (base_addr),
    .i_adv    (w_hs),
    .i_ch_clr (w_ch_clr),
    .o_addr   (w_addr),
    .o_ch_end (w_ch_end)
  );

  assign w_accept   = (r_state == ST_IDLE) && start;
  assign w_hs       = (r_state == ST_PUSH) && r_up_valid_in && up_ready_in;
  assign w_last_ch  = (r_ch_idx == CH_W'(NUM_CH - 1));

  // Counter saturates at OUT_PER_CH; a sample beyond that only raises err.
  assign w_cnt_en   = up_valid_out && r_busy;
  assign w_overflow = w_cnt_en && (r_out_cnt == OC_W'(OUT_PER_CH));
  assign w_stray    = up_valid_out && !r_busy;
  assign w_out_inc  = r_out_cnt + OC_W'(w_cnt_en && !w_overflow);
  assign w_cnt_hit  = (w_out_inc == OC_W'(OUT_PER_CH));
  assign w_ch_clr   = (r_state == ST_DRAIN) && w_cnt_hit && !w_last_ch;

  // NOTE: w_next is defaulted before the case so no path leaves it unassigned
  // (an unassigned path in always_comb would infer a latch).
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (start) w_next = ST_FETCH;
      ST_FETCH: w_next = ST_WAIT;
      ST_WAIT:  w_next = ST_PUSH;
      ST_PUSH:  if (w_hs) w_next = w_ch_end ? ST_DRAIN : ST_FETCH;
      ST_DRAIN: if (w_cnt_hit) w_next = w_last_ch ? ST_DONE : ST_FETCH;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_mem_rd_en   <= 1'b0;
      r_up_valid_in <= 1'b0;
      r_up_data_in  <= '0;
      r_out_cnt     <= '0;
      r_ch_idx      <= '0;
    end else begin
      r_state     <= w_next;
      r_busy      <= (w_next != ST_IDLE) && (w_next != ST_DONE);
      r_done      <= (w_next == ST_DONE);
      r_mem_rd_en <= (w_next == ST_FETCH);

      if (r_state == ST_WAIT) begin
        r_up_valid_in <= 1'b1;
        r_up_data_in  <= mem_rd_data;
      end else if (w_hs) begin
        r_up_valid_in <= 1'b0;
      end

      if (w_accept || w_ch_clr) r_out_cnt <= '0;
      else                      r_out_cnt <= w_out_inc;

      if (w_accept)      r_ch_idx <= '0;
      else if (w_ch_clr) r_ch_idx <= r_ch_idx + CH_W'(1);

      r_err <= (w_accept ? 1'b0 : r_err) | w_stray | w_overflow;
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;
  assign ch_idx      = r_ch_idx;
  assign mem_rd_en   = r_mem_rd_en;
  assign mem_addr    = w_addr;
  assign up_valid_in = r_up_valid_in;
  assign up_data_in  = r_up_data_in;

endmodule
